// File: rtl/fetch_seq.sv
// fetch_seq -- next-PC sequencer and PC write-enable controller for the
// fetch stage.
//
// Each cycle selects the next PC from exception entry, eret return, a
// branch/jump redirect or sequential pc+4. It also drives the PC write enable
// and a flush of the younger stages. A redirect that resolves while fetch is
// stalled is held in a single-entry buffer. The buffered target is applied on
// the first unstalled cycle.
//
// Parameters:
//   EXC_ENTRY      exception/interrupt handler address
//   RESET_PC       npc value driven while reset is high
// Ports:
//   clk            clock
//   reset          synchronous, active-high reset
//   stall          hazard stall; the PC must hold
//   pc[31:0]       current fetch PC
//   br_valid       branch/jump redirect resolves this cycle
//   br_target      redirect address
//   req            exception/interrupt request from CP0
//   eret           eret in flight (fetch is at epc this cycle)
//   epc[31:0]      exception return address
//   npc[31:0]      next PC (combinational)
//   pc_we          PC register write enable (combinational)
//   flush          flush younger pipeline stages (combinational)
//   redir_pending  a buffered redirect is held
//   stall_cnt      stall-cycle counter
//   redir_cnt      applied-redirect counter
//
// Optional feature macro: FETCH_PERF_CNT_EN. When it is defined, the two
// performance counters are built. When it is undefined, stall_cnt and
// redir_cnt are tied to zero.

module fetch_seq #(
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] npc,
  output logic        pc_we,
  output logic        flush,
  output logic        redir_pending,
  output logic [31:0] stall_cnt,
  output logic [31:0] redir_cnt
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    EXC  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pend_tgt;
  logic        pend_ld;
  logic        redir_fire;
  logic [31:0] pc_plus4;
  logic [31:0] epc_plus4;

  assign pc_plus4  = pc + 32'd4;
  assign epc_plus4 = epc + 32'd4;

  // Priority selection. The rules are evaluated in order and the first
  // match wins. EXC ignores br_valid because that branch belongs to a
  // flushed instruction.
  always_comb begin
    npc        = pc_plus4;
    pc_we      = !stall;
    flush      = 1'b0;
    state_nxt  = state;
    pend_ld    = 1'b0;
    redir_fire = 1'b0;
    if (reset) begin
      npc       = RESET_PC;
      pc_we     = 1'b0;
      state_nxt = RUN;
    end else if (req) begin
      npc       = EXC_ENTRY;
      pc_we     = 1'b1;
      flush     = 1'b1;
      state_nxt = EXC;
    end else if (eret) begin
      npc       = epc_plus4;
      pc_we     = 1'b1;
      flush     = 1'b1;
      state_nxt = EXC;
    end else begin
      unique case (state)
        EXC: begin
          state_nxt = RUN;
        end
        PEND: begin
          if (!stall) begin
            npc        = pend_tgt;
            pc_we      = 1'b1;
            state_nxt  = RUN;
            redir_fire = 1'b1;
          end
        end
        default: begin
          if (br_valid) begin
            if (!stall) begin
              npc        = br_target;
              pc_we      = 1'b1;
              redir_fire = 1'b1;
            end else begin
              pc_we     = 1'b0;
              pend_ld   = 1'b1;
              state_nxt = PEND;
            end
          end
        end
      endcase
    end
  end

  // Exception entry and eret leave the state as EXC. The stale buffered
  // target is then never read, so it is also cleared to keep the register
  // clean.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pend_tgt <= '0;
    end else begin
      state <= state_nxt;
      if (req || eret)
        pend_tgt <= '0;
      else if (pend_ld)
        pend_tgt <= br_target;
    end
  end

  assign redir_pending = (state == PEND);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] redir_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (stall)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (redir_fire)
        redir_cnt_q <= redir_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign redir_cnt = redir_cnt_q;
`else
  assign stall_cnt = '0;
  assign redir_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_seq.sv
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [31:0] pc;
  logic        br_valid;
  logic [31:0] br_target;
  logic        req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] npc;
  logic        pc_we;
  logic        flush;
  logic        redir_pending;
  logic [31:0] stall_cnt;
  logic [31:0] redir_cnt;

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    string       tag;
    logic [31:0] npc;
    logic        we;
    logic        fl;
    logic        pend;
    logic [31:0] scnt;
    logic [31:0] rcnt;
  } exp_t;

  exp_t sb[$];

  fetch_seq #(
    .EXC_ENTRY(32'h0000_4180),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .pc           (pc),
    .br_valid     (br_valid),
    .br_target    (br_target),
    .req          (req),
    .eret         (eret),
    .epc          (epc),
    .npc          (npc),
    .pc_we        (pc_we),
    .flush        (flush),
    .redir_pending(redir_pending),
    .stall_cnt    (stall_cnt),
    .redir_cnt    (redir_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Drive one cycle of stimulus (just after a posedge) and push its expectation.
  // The expectation is popped and compared at the following negedge.
  // Counter expectations are the values visible during this cycle.
  task automatic step(input string tag,
                      input logic r, input logic st, input logic [31:0] p,
                      input logic bv, input logic [31:0] bt,
                      input logic rq, input logic er, input logic [31:0] ep,
                      input logic [31:0] e_npc, input logic e_we, input logic e_fl,
                      input logic e_pend, input logic [31:0] e_s, input logic [31:0] e_r);
    exp_t e;
    exp_t got;
    reset = r; stall = st; pc = p; br_valid = bv; br_target = bt;
    req = rq; eret = er; epc = ep;
    e.tag = tag; e.npc = e_npc; e.we = e_we; e.fl = e_fl; e.pend = e_pend;
`ifdef FETCH_PERF_CNT_EN
    e.scnt = e_s; e.rcnt = e_r;
`else
    e.scnt = '0; e.rcnt = '0;
`endif
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    check({got.tag, ".npc"},       npc,                   got.npc);
    check({got.tag, ".pc_we"},     {31'd0, pc_we},        {31'd0, got.we});
    check({got.tag, ".flush"},     {31'd0, flush},        {31'd0, got.fl});
    check({got.tag, ".pending"},   {31'd0, redir_pending}, {31'd0, got.pend});
    check({got.tag, ".stall_cnt"}, stall_cnt,             got.scnt);
    check({got.tag, ".redir_cnt"}, redir_cnt,             got.rcnt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc = '0; br_valid = 1'b0; br_target = '0;
    req = 1'b0; eret = 1'b0; epc = '0;
    @(posedge clk);
    #1;
    //    tag        rst st pc            bv bt            rq er epc           npc           we fl pd s  r
    step("reset",     1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h3000,     0, 0, 0, 0, 0);
    step("seq",       0, 0, 32'h3000,     0, 32'h0,        0, 0, 32'h0,        32'h3004,     1, 0, 0, 0, 0);
    step("redir",     0, 0, 32'h3004,     1, 32'h3400,     0, 0, 32'h0,        32'h3400,     1, 0, 0, 0, 0);
    step("buf_load",  0, 1, 32'h3400,     1, 32'h3400,     0, 0, 32'h0,        32'h3404,     0, 0, 0, 0, 1);
    step("buf_hold1", 0, 1, 32'h3400,     1, 32'h3800,     0, 0, 32'h0,        32'h3404,     0, 0, 1, 1, 1);
    step("buf_hold2", 0, 1, 32'h3400,     1, 32'h3800,     0, 0, 32'h0,        32'h3404,     0, 0, 1, 2, 1);
    step("buf_apply", 0, 0, 32'h3400,     0, 32'h0,        0, 0, 32'h0,        32'h3400,     1, 0, 1, 3, 1);
    step("post_buf",  0, 0, 32'h3400,     0, 32'h0,        0, 0, 32'h0,        32'h3404,     1, 0, 0, 3, 2);
    step("pend2",     0, 1, 32'h3404,     1, 32'h3500,     0, 0, 32'h0,        32'h3408,     0, 0, 0, 3, 2);
    step("exc_prio",  0, 1, 32'h3404,     1, 32'h3600,     1, 1, 32'h3010,     32'h4180,     1, 1, 1, 4, 2);
    step("exc_ignbr", 0, 0, 32'h4180,     1, 32'h3700,     0, 0, 32'h0,        32'h4184,     1, 0, 0, 5, 2);
    step("after_exc", 0, 0, 32'h4184,     0, 32'h0,        0, 0, 32'h0,        32'h4188,     1, 0, 0, 5, 2);
    step("eret",      0, 0, 32'h4188,     0, 32'h0,        0, 1, 32'h3010,     32'h3014,     1, 1, 0, 5, 2);
    step("exc_stall", 0, 1, 32'h3014,     1, 32'h3900,     0, 0, 32'h0,        32'h3018,     0, 0, 0, 5, 2);
    step("pc_wrap",   0, 0, 32'hFFFF_FFFC, 0, 32'h0,       0, 0, 32'h0,        32'h0,        1, 0, 0, 6, 2);
    step("epc_wrap",  0, 0, 32'h3018,     0, 32'h0,        0, 1, 32'hFFFF_FFFC, 32'h0,       1, 1, 0, 6, 2);
    step("exc_seq",   0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        32'h4,        1, 0, 0, 6, 2);
    step("pend3",     0, 1, 32'h4,        1, 32'h3900,     0, 0, 32'h0,        32'h8,        0, 0, 0, 6, 2);
    step("rst_pend",  1, 1, 32'h4,        0, 32'h0,        0, 0, 32'h0,        32'h3000,     0, 0, 1, 7, 2);
    step("rst_hold",  1, 0, 32'h4,        0, 32'h0,        0, 0, 32'h0,        32'h3000,     0, 0, 0, 0, 0);
    step("rst_rel",   0, 0, 32'h3000,     0, 32'h0,        0, 0, 32'h0,        32'h3004,     1, 0, 0, 0, 0);
    step("req_stall", 0, 1, 32'h3004,     0, 32'h0,        1, 0, 32'h0,        32'h4180,     1, 1, 0, 0, 0);
    step("exc_end",   0, 0, 32'h4180,     0, 32'h0,        0, 0, 32'h0,        32'h4184,     1, 0, 0, 1, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
